// File: rtl/fifo_drain.sv
// Drains an upstream synchronous FIFO into a 2-entry valid/ready output buffer.
// Optional transfer counter on xfer_cnt when FIFO_DRAIN_CNT_EN is defined.
module fifo_drain #(
  parameter int FIFO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
`ifdef FIFO_DRAIN_CNT_EN
  output logic [15:0]           xfer_cnt,
`endif
  output logic                  rd_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t                  occ_q, occ_d;
  logic                  inflight_q;
  logic                  started_q;
  logic                  err_q;
  logic [FIFO_WIDTH-1:0] head_q, tail_q;
  logic                  push, pop;
  logic [2:0]            level;

  assign push    = inflight_q;
  assign pop     = m_valid && m_ready;
  assign m_valid = (occ_q != EMPTY);
  assign m_data  = head_q;
  assign rd_err  = err_q;

  // Occupancy after this cycle, counting the word already in flight.
  always_comb begin
    level      = {1'b0, occ_q} + {2'b00, push} - {2'b00, pop};
    fifo_rd_en = started_q && !fifo_empty && (level < 3'd2);
  end

  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      EMPTY:   if (push) occ_d = ONE;
      ONE: begin
        if (push && !pop)      occ_d = TWO;
        else if (pop && !push) occ_d = EMPTY;
      end
      TWO:     if (pop) occ_d = ONE;
      default: occ_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= EMPTY;
      inflight_q <= 1'b0;
      started_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      started_q  <= 1'b1;
      if (push && fifo_underflow) err_q <= 1'b1;
    end
  end

  // Head is always the oldest word; a pop shifts tail forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (push && pop) begin
      if (occ_q == ONE) begin
        head_q <= fifo_data_out;
      end else begin
        head_q <= tail_q;
        tail_q <= fifo_data_out;
      end
    end else if (push) begin
      if (occ_q == EMPTY) head_q <= fifo_data_out;
      else                tail_q <= fifo_data_out;
    end else if (pop) begin
      head_q <= tail_q;
    end
  end

`ifdef FIFO_DRAIN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   xfer_cnt <= 16'h0000;
    else if (pop) xfer_cnt <= xfer_cnt + 16'h0001;
  end
`endif

endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16: data width, equal to the upstream FIFO data width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL have port fifo_rd_en  output  1  read request to the upstream FIFO.
REQ-005 SHALL have port fifo_data_out  input  FIFO_WIDTH  FIFO read data, valid on the cycle after fifo_rd_en was sampled high.
REQ-006 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 SHALL have port fifo_underflow  input  1  upstream FIFO underflow flag.
REQ-008 SHALL have port m_valid  output  1  downstream beat valid.
REQ-009 SHALL have port m_data  output  FIFO_WIDTH  downstream beat data.
REQ-010 SHALL have port m_ready  input  1  downstream accept; a beat transfers when m_valid and m_ready are high at the same clock edge.
REQ-011 SHALL have port rd_err  output  1  sticky error flag.

Function
REQ-012 SHALL hold a 2-entry in-order output buffer; occupancy state is EMPTY (0), ONE (1) or TWO (2).
REQ-013 SHALL keep a registered inflight flag: set on any cycle fifo_rd_en is 1, clear otherwise.
REQ-014 SHALL drive fifo_rd_en = !fifo_empty && (occ + inflight - pop) < 2, where pop = m_valid && m_ready in the same cycle (combinational path from m_ready permitted).
REQ-015 SHALL write fifo_data_out into the buffer tail on every cycle inflight is 1; data never dropped.
REQ-016 SHALL drive m_valid = (occ != 0) and m_data = buffer head, both from registers only.
REQ-017 SHALL, once m_valid is high, keep m_valid high and m_data stable until the beat transfers.
REQ-018 SHALL apply simultaneous push and pop in one cycle: occupancy unchanged, order preserved.
REQ-019 State transitions: EMPTY->ONE on push; ONE->TWO on push without pop; ONE->EMPTY on pop without push; TWO->ONE on pop; TWO with push SHALL be unreachable by REQ-014.
REQ-020 SHALL sustain one beat per cycle when fifo_empty stays 0 and m_ready stays 1; first-word latency: fifo_rd_en at cycle N, m_valid at cycle N+2.
REQ-021 SHALL set rd_err when fifo_underflow is 1 on a cycle inflight is 1, and hold it until reset; the beat is still buffered.
REQ-022 SHALL never assert fifo_rd_en while fifo_empty is 1.

Reset
REQ-023 SHALL, while rst_n is 0, force fifo_rd_en=0, m_valid=0, m_data=0, rd_err=0, occupancy EMPTY, inflight=0.
REQ-024 SHALL discard buffered and in-flight data when reset is asserted mid-transfer; no beat presented after release unless newly read.
REQ-025 SHALL not assert fifo_rd_en before the first rising clk edge after rst_n deasserts.

Configuration
REQ-026 SHALL, with macro FIFO_DRAIN_CNT_EN defined, add port xfer_cnt  output  16: count of transferred beats, reset 0, +1 per transfer, wraps 16'hFFFF->0.
REQ-027 SHALL, without FIFO_DRAIN_CNT_EN, omit xfer_cnt and its counter entirely; all other behaviour identical.

Verification
REQ-028 Reset: rst_n=0 mid-stream with occ=2 -> all outputs 0 same cycle; after release with fifo_empty=1, m_valid stays 0.
REQ-029 Streaming: FIFO preloaded 8 words 0x0001..0x0008, m_ready=1 -> 8 consecutive beats in order, m_valid high cycles N+2..N+9, fifo_rd_en never high with fifo_empty=1.
REQ-030 Backpressure: 8 words loaded, m_ready=0 -> exactly 2 reads, m_valid=1, m_data=0x0001 held; m_ready=1 -> remaining 6 delivered in order, none lost or duplicated.
REQ-031 Random m_ready (50%) over 1000 words -> output sequence equals input sequence; occupancy never exceeds 2.
REQ-032 Forced fifo_underflow=1 during an in-flight read -> rd_err=1 next cycle, stays 1 until rst_n=0.
REQ-033 With FIFO_DRAIN_CNT_EN: 65537 transfers -> xfer_cnt=1.
